// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline hazard unit.
//
// Contents: default register-number width and producer-stage count,
// forwarding-select encodings, the halt FSM state type, and the
// compile-time forwarding switch.
//
// Build option: define HAZ_FORWARD_EN to enable operand forwarding.
// Without it, the unit behaves as a pure interlock: forwarding selects stay
// at the register file, and any match in a stage that has not yet written
// back causes a stall.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int NSTAGE_DEF = 3;

  // Forwarding mux select values: 0 = register file, i+1 = producer stage i.
  localparam int FWD_REGFILE = 0;
  localparam int FWD_EX      = 1;
  localparam int FWD_MEM     = 2;
  localparam int FWD_WB      = 3;

  typedef enum logic {
    HS_RUN,
    HS_HALTED
  } halt_state_e;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD_MODE = 1'b1;
`else
  localparam bit FWD_MODE = 1'b0;
`endif

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// hazard_match -- youngest-producer priority encoder for one source operand.
//
// Ports:
//   used      in  operand is read by the ID instruction
//   num       in  operand register number
//   st_wr     in  per-stage RegWrite (bit i = stage i, 0 = youngest)
//   st_load   in  per-stage MemtoReg
//   st_num    in  per-stage destination numbers, stage i at [i*REG_AW +: REG_AW]
//   hit       out some stage will write this operand
//   idx       out index of the youngest such stage (0 when no hit)
//   not_ready out the youngest producer cannot supply the value this cycle
//
// Behaviour depends on HAZ_FORWARD_EN through pipe_pkg::FWD_MODE.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(NSTAGE + 1)
) (
  input  logic                     used,
  input  logic [REG_AW-1:0]        num,
  input  logic [NSTAGE-1:0]        st_wr,
  input  logic [NSTAGE-1:0]        st_load,
  input  logic [NSTAGE*REG_AW-1:0] st_num,
  output logic                     hit,
  output logic [SEL_W-1:0]         idx,
  output logic                     not_ready
);

  always_comb begin
    int   hit_stage;
    logic hit_load;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    hit       = 1'b0;
    idx       = '0;
    not_ready = 1'b0;
    hit_stage = NSTAGE;
    hit_load  = 1'b0;

    // Scan oldest to youngest so the lowest matching index is kept last.
    // Register zero is hard-wired and never creates a dependency.
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (used && (num != '0) && st_wr[i] && (st_num[i*REG_AW +: REG_AW] == num)) begin
        hit       = 1'b1;
        hit_stage = i;
        hit_load  = st_load[i];
      end
    end

    if (hit) begin
      idx = SEL_W'(hit_stage);
      if (FWD_MODE) begin
        // A load still in its first LOAD_LAT stages has no data on the bypass.
        not_ready = hit_load && (hit_stage < LOAD_LAT);
      end else begin
        // Without bypass paths only the write-back stage is safe: it writes
        // the register file before ID reads it.
        not_ready = (hit_stage < NSTAGE - 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit -- RAW detection, forwarding select, branch flush,
// syscall halt/resume and hazard statistics for the in-order pipeline.
//
// Ports:
//   clk, CLR                 clock; asynchronous active-high reset
//   rs_used/rt_used          ID instruction reads rs/rt
//   rs_num/rt_num            ID source register numbers
//   st_wr/st_load/st_num     producer stage write info (stage 0 = EX)
//   branch_taken             EX resolved a taken branch/jump
//   syscall_halt             WB syscall requests halt
//   go                       resume button level
//   fwd_rs/fwd_rt            operand source: 0 = regfile, i+1 = stage i
//   pc_en/ifid_en            PC and IF/ID enables
//   ifid_flush/idex_bubble   bubble inserts
//   halt                     pipeline frozen (registered)
//   stall_cnt/flush_cnt/halt_cnt  saturating statistics
//
// Build option: HAZ_FORWARD_EN enables forwarding (see pipe_pkg).
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          CLR,
  input  logic                          rs_used,
  input  logic                          rt_used,
  input  logic [REG_AW-1:0]             rs_num,
  input  logic [REG_AW-1:0]             rt_num,
  input  logic [NSTAGE-1:0]             st_wr,
  input  logic [NSTAGE-1:0]             st_load,
  input  logic [NSTAGE*REG_AW-1:0]      st_num,
  input  logic                          branch_taken,
  input  logic                          syscall_halt,
  input  logic                          go,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt,
  output logic                          pc_en,
  output logic                          ifid_en,
  output logic                          ifid_flush,
  output logic                          idex_bubble,
  output logic                          halt,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt,
  output logic [CNT_W-1:0]              halt_cnt
);

  localparam int SEL_W = $clog2(NSTAGE + 1);

  logic             rs_hit, rt_hit, rs_nr, rt_nr;
  logic [SEL_W-1:0] rs_idx, rt_idx;
  logic             data_stall, stall_win, flush_win;
  logic             go_q, go_rise;
  halt_state_e      state_q, state_d;

  hazard_match #(
    .NSTAGE(NSTAGE), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_rs (
    .used(rs_used), .num(rs_num), .st_wr(st_wr), .st_load(st_load),
    .st_num(st_num), .hit(rs_hit), .idx(rs_idx), .not_ready(rs_nr)
  );

  hazard_match #(
    .NSTAGE(NSTAGE), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_rt (
    .used(rt_used), .num(rt_num), .st_wr(st_wr), .st_load(st_load),
    .st_num(st_num), .hit(rt_hit), .idx(rt_idx), .not_ready(rt_nr)
  );

  assign fwd_rs = (FWD_MODE && rs_hit) ? rs_idx + SEL_W'(1) : SEL_W'(FWD_REGFILE);
  assign fwd_rt = (FWD_MODE && rt_hit) ? rt_idx + SEL_W'(1) : SEL_W'(FWD_REGFILE);

  assign data_stall = rs_nr | rt_nr;
  assign halt       = (state_q == HS_HALTED);
  assign go_rise    = go & ~go_q;

  // Priority: halt freezes everything, a taken branch squashes the dependent
  // instruction so its stall is moot, otherwise a data stall holds IF/ID.
  assign flush_win = !halt && branch_taken;
  assign stall_win = !halt && !branch_taken && data_stall;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (halt) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (data_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // A go edge can only resume from HALTED, so a go edge coinciding with the
  // halting syscall is naturally ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HS_RUN:    if (syscall_halt) state_d = HS_HALTED;
      HS_HALTED: if (go_rise)      state_d = HS_RUN;
      default:   state_d = HS_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= HS_RUN;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      halt_cnt  <= '0;
    end else begin
      if (stall_win && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_win && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (halt && go_rise && (halt_cnt != '1)) halt_cnt <= halt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit -- directed scenarios plus randomized stimulus checked
// against a behavioural model of the hazard rules. The model follows the
// HAZ_FORWARD_EN build option of the compile.
module tb_pipe_hazard_unit;

  localparam int NS  = 3;
  localparam int RA  = 5;
  localparam int LL  = 1;
  localparam int CW  = 4;
  localparam int SW  = $clog2(NS + 1);
  localparam int MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              CLR;
  logic              rs_used, rt_used;
  logic [RA-1:0]     rs_num, rt_num;
  logic [NS-1:0]     st_wr, st_load;
  logic [NS*RA-1:0]  st_num;
  logic              branch_taken, syscall_halt, go;
  logic [SW-1:0]     fwd_rs, fwd_rt;
  logic              pc_en, ifid_en, ifid_flush, idex_bubble, halt;
  logic [CW-1:0]     stall_cnt, flush_cnt, halt_cnt;

  pipe_hazard_unit #(.NSTAGE(NS), .REG_AW(RA), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .CLR(CLR),
    .rs_used(rs_used), .rt_used(rt_used), .rs_num(rs_num), .rt_num(rt_num),
    .st_wr(st_wr), .st_load(st_load), .st_num(st_num),
    .branch_taken(branch_taken), .syscall_halt(syscall_halt), .go(go),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .halt_cnt(halt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_halted;
  bit m_go_q;
  int m_stall, m_flush, m_halts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Index of the youngest stage writing this operand, or -1.
  function automatic int youngest(input logic used, input logic [RA-1:0] num);
    if (!used || num == 0) return -1;
    for (int i = 0; i < NS; i++)
      if (st_wr[i] && st_num[i*RA +: RA] == num) return i;
    return -1;
  endfunction

  function automatic bit operand_hazard(input int y);
    if (y < 0) return 1'b0;
`ifdef HAZ_FORWARD_EN
    return st_load[y] && (y < LL);
`else
    return y < NS - 1;
`endif
  endfunction

  function automatic int fwd_sel(input int y);
`ifdef HAZ_FORWARD_EN
    return y + 1;
`else
    return (y >= 0) ? 0 : 0;
`endif
  endfunction

  function automatic bit model_stall();
    return operand_hazard(youngest(rs_used, rs_num)) ||
           operand_hazard(youngest(rt_used, rt_num));
  endfunction

  task automatic model_reset();
    m_halted = 1'b0;
    m_go_q   = 1'b0;
    m_stall  = 0;
    m_flush  = 0;
    m_halts  = 0;
  endtask

  task automatic model_clock();
    bit stall;
    if (CLR) begin
      model_reset();
      return;
    end
    stall = model_stall();
    if (!m_halted && branch_taken)       m_flush = (m_flush == MAX) ? MAX : m_flush + 1;
    else if (!m_halted && stall)         m_stall = (m_stall == MAX) ? MAX : m_stall + 1;
    if (!m_halted) begin
      if (syscall_halt) m_halted = 1'b1;
    end else if (go && !m_go_q) begin
      m_halted = 1'b0;
      m_halts  = (m_halts == MAX) ? MAX : m_halts + 1;
    end
    m_go_q = go;
  endtask

  task automatic check_outputs();
    bit stall, frozen, moving;
    stall  = model_stall();
    frozen = m_halted;
    moving = !frozen && (branch_taken || !stall);
    check("fwd_rs", 32'(fwd_rs), 32'(fwd_sel(youngest(rs_used, rs_num))));
    check("fwd_rt", 32'(fwd_rt), 32'(fwd_sel(youngest(rt_used, rt_num))));
    check("pc_en", 32'(pc_en), 32'(moving));
    check("ifid_en", 32'(ifid_en), 32'(moving));
    check("ifid_flush", 32'(ifid_flush), 32'(!frozen && branch_taken));
    check("idex_bubble", 32'(idex_bubble), 32'(!frozen && (branch_taken || stall)));
    check("halt", 32'(halt), 32'(m_halted));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    check("halt_cnt", 32'(halt_cnt), 32'(m_halts));
  endtask

  // Called just after a rising edge with inputs already driven: check in the
  // middle of the cycle, then advance the model at the next edge.
  task automatic step();
    #4;
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    rs_used = 0; rt_used = 0; rs_num = '0; rt_num = '0;
    st_wr = '0; st_load = '0; st_num = '0;
    branch_taken = 0; syscall_halt = 0; go = 0;
  endtask

  task automatic set_stage(input int i, input bit wr, input bit ld, input int num);
    st_wr[i]   = wr;
    st_load[i] = ld;
    st_num[i*RA +: RA] = RA'(num);
  endtask

  task automatic load_use_r9();
    clear_inputs();
    set_stage(0, 1, 1, 9);
    rt_used = 1; rt_num = 9;
  endtask

  initial begin
    CLR = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    step();                      // reset state with CLR held
    CLR = 1'b0;

    // Youngest of two producers of r8
    clear_inputs();
    rs_used = 1; rs_num = 8;
    set_stage(0, 1, 0, 8);
    set_stage(1, 1, 0, 8);
    step();

    // Load-use on r9, then the load has advanced to stage 1
    load_use_r9();
    step();
    clear_inputs();
    set_stage(1, 1, 1, 9);
    rt_used = 1; rt_num = 9;
    step();

    // Register zero never matches
    clear_inputs();
    set_stage(0, 1, 0, 0);
    rs_used = 1; rs_num = 0;
    step();

    // Load-use together with a taken branch
    load_use_r9();
    branch_taken = 1;
    step();

    // Halt, resume with go held three cycles, halt again
    clear_inputs();
    syscall_halt = 1; go = 1;    // go edge alongside the syscall is ignored
    step();
    syscall_halt = 1; go = 0;    // held syscall while halted is ignored
    step();
    syscall_halt = 0;
    go = 1;
    repeat (3) step();
    go = 0;
    step();
    syscall_halt = 1;
    step();
    syscall_halt = 0;
    step();

    // Asynchronous clear mid-cycle while halted
    #2;
    CLR = 1'b1;
    #1;
    check("clr_halt", 32'(halt), 32'd0);
    check("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    check("clr_halt_cnt", 32'(halt_cnt), 32'd0);
    model_reset();
    step();
    CLR = 1'b0;

    // Saturation: stall held for 20 cycles
    load_use_r9();
    repeat (20) step();
    check("stall_sat", 32'(stall_cnt), 32'(MAX));

    // ALU result in stage 1, then only in the WB stage
    clear_inputs();
    rs_used = 1; rs_num = 5;
    set_stage(1, 1, 0, 5);
    step();
    clear_inputs();
    rs_used = 1; rs_num = 5;
    set_stage(2, 1, 0, 5);
    step();

    // Randomized traffic on a small register set so matches are frequent
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        CLR = 1'b1;
        model_reset();
      end else begin
        CLR = 1'b0;
      end
      rs_used = 1'($urandom_range(0, 1));
      rt_used = 1'($urandom_range(0, 1));
      rs_num  = RA'($urandom_range(0, 3));
      rt_num  = RA'($urandom_range(0, 3));
      st_wr   = NS'($urandom);
      st_load = NS'($urandom);
      for (int i = 0; i < NS; i++) st_num[i*RA +: RA] = RA'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 4) == 0);
      syscall_halt = ($urandom_range(0, 9) == 0);
      go           = 1'($urandom_range(0, 1));
      step();
    end
    CLR = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised successor to the 5-stage pipeline's bubble/halt logic: one block owns RAW hazard detection, operand forwarding select, branch flush, syscall halt/resume and hazard statistics.
- Sits beside the ID stage. Consumes decoded source register numbers plus write-back info from NSTAGE downstream producer stages (index 0 = EX, youngest).
- Drives the PC, IF/ID and ID/EX enables and bubbles, and the forwarding mux selects.

Parameters:
- NSTAGE, 3, number of producer stages after ID (EX, MEM, WB); valid range 2..6.
- REG_AW, 5, register-number width.
- LOAD_LAT, 1, stages a load result trails ALU results; a load in stage i < LOAD_LAT is not forwardable.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- CLR  in  1  reset; asynchronous, active-high.
- rs_used  in  1  ID instruction reads rs.
- rt_used  in  1  ID instruction reads rt.
- rs_num  in  REG_AW  rs register number.
- rt_num  in  REG_AW  rt register number.
- st_wr  in  NSTAGE  per-stage RegWrite (bit i = stage i).
- st_load  in  NSTAGE  per-stage MemtoReg.
- st_num  in  NSTAGE*REG_AW  per-stage destination register number; stage i occupies bits [i*REG_AW +: REG_AW].
- branch_taken  in  1  EX resolved a taken branch or jump.
- syscall_halt  in  1  WB-stage syscall requesting halt.
- go  in  1  resume button level (unsynchronised level, one sample per clk).
- fwd_rs  out  $clog2(NSTAGE+1)  rs source: 0 = regfile, i+1 = stage i.
- fwd_rt  out  $clog2(NSTAGE+1)  rt source, same encoding.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID bubble.
- idex_bubble  out  1  ID/EX bubble.
- halt  out  1  pipeline frozen.
- stall_cnt  out  CNT_W  data-stall cycles.
- flush_cnt  out  CNT_W  branch-flush cycles.
- halt_cnt  out  CNT_W  completed halts.

Behaviour:
- Match rule: stage i matches operand x when x_used, st_wr[i] and st_num_i == x_num, and x_num != 0. Only the youngest matching stage (lowest i) counts.
- Hazard: the youngest match has st_load[i] and i < LOAD_LAT, so its data is not ready.
- Combinational outputs: fwd_rs = youngest match + 1, else 0; same for fwd_rt. data_stall = hazard on rs OR on rt.
- Priority, highest first: halt, then branch_taken, then data_stall.
- halt = 1: pc_en = ifid_en = 0, ifid_flush = idex_bubble = 0 (full freeze; downstream stages also freeze on halt).
- branch_taken = 1: pc_en = ifid_en = 1, ifid_flush = idex_bubble = 1. A simultaneous data_stall is ignored because the dependent instruction is squashed.
- data_stall = 1: pc_en = ifid_en = 0, idex_bubble = 1, ifid_flush = 0.
- Otherwise: pc_en = ifid_en = 1, both bubbles 0.
- Halt FSM, states RUN/HALTED:
  - RUN -> HALTED on syscall_halt while in RUN.
  - HALTED -> RUN on a go rising edge, detected against a registered go_q.
  - halt = (state == HALTED), registered. It rises the cycle after syscall_halt.
  - syscall_halt held while HALTED is ignored. A go edge on the same cycle as syscall_halt in RUN does not resume.
- Counters, all saturating at 2^CNT_W-1, never wrapping:
  - stall_cnt +1 per cycle data_stall wins priority.
  - flush_cnt +1 per cycle branch_taken wins priority.
  - halt_cnt +1 on each HALTED -> RUN transition.
- Reset (async, CLR = 1):
  - State RUN, go_q = 0, all counters 0, halt = 0.
  - Combinational outputs follow their inputs with halt = 0.
  - CLR asserted mid-halt returns to RUN immediately.

Optional Feature:
- Macro HAZ_FORWARD_EN.
- Defined: forwarding as above; only load hazards within LOAD_LAT stall.
- Undefined: fwd_rs = fwd_rt = 0 always, and any match in any stage with i < NSTAGE-1 is a data_stall (no-forwarding interlock; WB writes the regfile before ID reads, so stage NSTAGE-1 never stalls). Counters and FSM are unchanged.

Decomposition:
- Shared package pipe_pkg:
  - REG_AW default and NSTAGE default.
  - Fwd-select encoding constants FWD_REGFILE = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3.
  - Halt-state enum {HS_RUN, HS_HALTED}.
- One natural sub-module, hazard_match: a per-operand youngest-match priority encoder, instantiated twice (rs, rt). It returns the match-valid flag, the stage index and the not-ready flag.

Test Plan:
- Forwarding, HAZ_FORWARD_EN defined: rs_num = 8, rs_used = 1; stage0 wr = 1, num = 8, load = 0; stage1 also writes 8 -> fwd_rs = 1 (youngest wins), pc_en = 1, no bubble, stall_cnt unchanged.
- Load-use: stage0 load to r9, rt_num = 9, rt_used = 1 -> pc_en = ifid_en = 0, idex_bubble = 1, stall_cnt 0 -> 1. Next cycle (load in stage1) -> fwd_rt = 2, no stall.
- Register zero and branch priority:
  - Stage0 writes r0, rs_num = 0 -> fwd_rs = 0, no stall.
  - Load-use plus branch_taken together -> ifid_flush = idex_bubble = 1, pc_en = 1, flush_cnt +1, stall_cnt unchanged.
- Halt/resume:
  - Pulse syscall_halt -> halt = 1 next cycle, pc_en = 0.
  - Hold go = 1 for 3 cycles -> single resume, halt = 0 next cycle, halt_cnt = 1.
  - Re-raise syscall_halt -> halts again.
- Reset and saturation:
  - Assert CLR while HALTED, mid-cycle -> halt = 0 immediately, counters 0.
  - With CNT_W = 4, hold a stall 20 cycles -> stall_cnt stops at 15.
- Interlock build (macro undefined): ALU result in stage1 matching rs -> stall, fwd_rs = 0; match only in stage2 (WB) -> no stall.
